// File: rtl/iir_decimator.sv
// iir_decimator: integrate-and-dump decimator that follows the IIR section.
// Sums blocks of 2^decim_log2 valid samples, rounds the block average
// (half toward +inf), saturates it to out_width and holds it in a
// valid/ready output register. A result that finds the register still
// full is dropped and latches the sticky overrun flag.
module iir_decimator #(
    parameter int bitwidth   = 32,
    parameter int out_width  = 16,
    parameter int decim_log2 = 2,
    parameter int frac_shift = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [bitwidth-1:0]  in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [out_width-1:0] out_data,
    output logic                        out_sat,
    output logic                        overrun
);

    // The accumulator carries decim_log2 guard bits so a full block cannot
    // overflow; the rounding add gets one more bit on top of that.
    localparam int acc_w   = bitwidth + decim_log2;
    localparam int rnd_w   = acc_w + 1;
    localparam int shift_k = decim_log2 + frac_shift;
    localparam int cnt_w   = (decim_log2 > 0) ? decim_log2 : 1;

    localparam logic [cnt_w-1:0] cnt_last = cnt_w'((1 << decim_log2) - 1);

    // Rounding constant 2^(shift_k-1), which collapses to 0 when shift_k is 0.
    localparam logic [rnd_w:0] half_wide = ({{rnd_w{1'b0}}, 1'b1} << shift_k) >> 1;
    localparam logic signed [rnd_w-1:0] half_lsb = half_wide[rnd_w-1:0];

    // Saturation limits of a signed out_width value, sign-extended to rnd_w.
    localparam logic signed [rnd_w-1:0] max_v =
        {{(rnd_w - out_width + 1){1'b0}}, {(out_width - 1){1'b1}}};
    localparam logic signed [rnd_w-1:0] min_v =
        {{(rnd_w - out_width + 1){1'b1}}, {(out_width - 1){1'b0}}};

    logic signed [acc_w-1:0]     acc;
    logic        [cnt_w-1:0]     cnt;
    logic                        block_done;
    logic signed [rnd_w-1:0]     sum_full;
    logic signed [rnd_w-1:0]     rounded;
    logic signed [rnd_w-1:0]     shifted;
    logic signed [out_width-1:0] res_data;
    logic                        res_sat;

    // Block-completion result: full sum, round, arithmetic shift, saturate.
    always_comb begin
        block_done = in_valid && (cnt == cnt_last);
        sum_full   = rnd_w'(acc) + rnd_w'(in_data);
        rounded    = sum_full + half_lsb;
        shifted    = rounded >>> shift_k;
        res_data   = shifted[out_width-1:0];
        res_sat    = 1'b0;
        if (shifted > max_v) begin
            res_data = max_v[out_width-1:0];
            res_sat  = 1'b1;
        end else if (shifted < min_v) begin
            res_data = min_v[out_width-1:0];
            res_sat  = 1'b1;
        end
    end

    // Integrate valid samples; the final sample of a block empties the accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (in_valid) begin
            if (block_done) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc + acc_w'(in_data);
                cnt <= cnt + cnt_w'(1);
            end
        end
    end

    // Output register: load when empty or draining, otherwise drop and flag overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            overrun   <= 1'b0;
        end else if (block_done) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                out_data  <= res_data;
                out_sat   <= res_sat;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iir_decimator.sv
// tb_iir_decimator: directed stimulus for iir_decimator with a block-average
// reference model that is checked against the DUT after every clock edge,
// plus literal expectations on the results the DUT hands downstream.
module tb_iir_decimator;

    localparam int bitwidth   = 32;
    localparam int out_width  = 16;
    localparam int decim_log2 = 2;
    localparam int frac_shift = 0;
    localparam int decim      = 1 << decim_log2;
    localparam int shift_k    = decim_log2 + frac_shift;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        in_valid;
    logic signed [bitwidth-1:0]  in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [out_width-1:0] out_data;
    logic                        out_sat;
    logic                        overrun;

    int errors = 0;
    int checks = 0;

    // Reference model state
    longint sample_q[$];
    bit     exp_valid = 0;
    longint exp_data  = 0;
    bit     exp_sat   = 0;
    bit     exp_ovr   = 0;
    bit     in_reset  = 0;

    // Log of what the DUT actually handed downstream
    bit     prev_valid = 0;
    longint prev_data  = 0;
    bit     prev_sat   = 0;
    longint last_xfer  = 0;
    bit     last_sat   = 0;
    int     xfer_count = 0;

    iir_decimator #(
        .bitwidth  (bitwidth),
        .out_width (out_width),
        .decim_log2(decim_log2),
        .frac_shift(frac_shift)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .overrun  (overrun)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Average of one block: round half toward +inf, then clip to out_width.
    function automatic void blockResult(input longint s, output longint r, output bit sat);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (out_width - 1)) - 1;
        lo = -(longint'(1) <<< (out_width - 1));
        if (shift_k > 0) r = (s + (longint'(1) <<< (shift_k - 1))) >>> shift_k;
        else r = s;
        sat = 0;
        if (r > hi) begin r = hi; sat = 1; end
        else if (r < lo) begin r = lo; sat = 1; end
    endfunction

    // After each edge: log the DUT transfer, advance the model, compare outputs.
    always @(posedge clk) begin
        longint s;
        longint r;
        bit     sat;
        #1;
        if (!rst && prev_valid && out_ready) begin
            last_xfer = prev_data;
            last_sat  = prev_sat;
            xfer_count++;
        end
        in_reset = rst;
        if (rst) begin
            sample_q.delete();
            exp_valid = 0;
            exp_data  = 0;
            exp_sat   = 0;
            exp_ovr   = 0;
        end else begin
            bit drained;
            drained = exp_valid && out_ready;
            if (drained) exp_valid = 0;
            if (in_valid) begin
                sample_q.push_back(longint'(in_data));
                if (sample_q.size() == decim) begin
                    s = 0;
                    foreach (sample_q[i]) s += sample_q[i];
                    sample_q.delete();
                    blockResult(s, r, sat);
                    if (!exp_valid) begin
                        exp_valid = 1;
                        exp_data  = r;
                        exp_sat   = sat;
                    end else begin
                        exp_ovr = 1;
                    end
                end
            end
        end
        checkOutput("out_valid", longint'(out_valid), longint'(exp_valid));
        checkOutput("overrun", longint'(overrun), longint'(exp_ovr));
        if (exp_valid || in_reset) begin
            checkOutput("out_data", longint'(out_data), exp_data);
            checkOutput("out_sat", longint'(out_sat), longint'(exp_sat));
        end
        prev_valid = out_valid;
        prev_data  = longint'(out_data);
        prev_sat   = out_sat;
    end

    // Drive one cycle of inputs just after the edge, to be sampled at the next edge.
    task automatic applyStimulus(input bit r, input bit v, input int d, input bit rdy);
        @(posedge clk);
        #2;
        rst       = r;
        in_valid  = v;
        in_data   = bitwidth'(d);
        out_ready = rdy;
    endtask

    task automatic feedBlock(input int a, input int b, input int c, input int d, input bit rdy);
        applyStimulus(0, 1, a, rdy);
        applyStimulus(0, 1, b, rdy);
        applyStimulus(0, 1, c, rdy);
        applyStimulus(0, 1, d, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, rdy);
    endtask

    // Directed sequence
    initial begin
        int count_before;
        rst       = 1;
        in_valid  = 0;
        in_data   = '0;
        out_ready = 1;
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        idle(2, 1);

        count_before = xfer_count;
        feedBlock(100, 100, 100, 100, 1);
        idle(3, 1);
        checkOutput("xfer_100", last_xfer, 100);
        checkOutput("xfer_100_sat", longint'(last_sat), 0);
        checkOutput("xfer_100_count", xfer_count, count_before + 1);

        feedBlock(10, 10, 10, 11, 1);
        idle(3, 1);
        checkOutput("xfer_round_10", last_xfer, 10);

        feedBlock(-1, -1, -1, -1, 1);
        idle(3, 1);
        checkOutput("xfer_minus1", last_xfer, -1);

        feedBlock(-1, -1, 0, 0, 1);
        idle(3, 1);
        checkOutput("xfer_half_up", last_xfer, 0);

        feedBlock(40000, 40000, 40000, 40000, 1);
        idle(3, 1);
        checkOutput("xfer_sat_pos", last_xfer, 32767);
        checkOutput("xfer_sat_pos_flag", longint'(last_sat), 1);

        feedBlock(-40000, -40000, -40000, -40000, 1);
        idle(3, 1);
        checkOutput("xfer_sat_neg", last_xfer, -32768);
        checkOutput("xfer_sat_neg_flag", longint'(last_sat), 1);

        count_before = xfer_count;
        applyStimulus(0, 1, 4, 1);
        applyStimulus(0, 0, 99, 1);
        applyStimulus(0, 0, 99, 1);
        applyStimulus(0, 1, 8, 1);
        applyStimulus(0, 0, 99, 1);
        applyStimulus(0, 1, 12, 1);
        applyStimulus(0, 1, 16, 1);
        idle(3, 1);
        checkOutput("xfer_gaps", last_xfer, 10);
        checkOutput("xfer_gaps_count", xfer_count, count_before + 1);

        count_before = xfer_count;
        feedBlock(5, 5, 5, 5, 0);
        feedBlock(9, 9, 9, 9, 0);
        idle(2, 0);
        checkOutput("stall_hold_data", longint'(out_data), 5);
        checkOutput("stall_overrun", longint'(overrun), 1);
        idle(3, 1);
        checkOutput("stall_xfer", last_xfer, 5);
        checkOutput("stall_xfer_count", xfer_count, count_before + 1);
        checkOutput("stall_drained", longint'(out_valid), 0);

        applyStimulus(0, 1, 1000, 1);
        applyStimulus(0, 1, 1000, 1);
        applyStimulus(1, 0, 0, 1);
        feedBlock(4, 4, 4, 4, 1);
        idle(3, 1);
        checkOutput("reset_clears_sum", last_xfer, 4);
        checkOutput("reset_clears_overrun", longint'(overrun), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iir_decimator.md
Name: iir_decimator

Overview:
- Downstream stage of the 2nd-order IIR section.
- Consumes the filter's signed output stream and decimates it by a power-of-two factor using block averaging (integrate-and-dump).
- Rounds and saturates each block average to a narrower output width.
- Presents each result through a valid/ready output register, so downstream logic (DAC serializer, capture FIFO) can stall without corrupting the filter path.

Parameters:
- bitwidth, 32, width of input sample (matches filter output y)
- out_width, 16, width of output sample, signed; must be <= bitwidth
- decim_log2, 2, log2 of decimation factor D (D = 4); range 0..8
- frac_shift, 0, extra right shift applied after averaging, to drop fixed-point fraction bits

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  in_data holds a sample this cycle
- in_data  input  bitwidth  signed input sample (filter y)
- out_valid  output  1  out_data holds an unconsumed result
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  out_width  signed decimated, rounded, saturated sample
- out_sat  output  1  out_data was clipped (qualified by out_valid)
- overrun  output  1  sticky; a result was dropped because the output register was still full

Behaviour:
- Reset (rst=1 at a clk edge):
  - acc=0, cnt=0, out_valid=0, out_data=0, out_sat=0, overrun=0.
  - Reset mid-block discards the partial sum.
  - rst has priority over every other event.
- Accumulator and counter:
  - acc is signed, bitwidth+decim_log2 bits, so it never overflows.
  - cnt counts 0..D-1.
  - Cycles with in_valid=0 change nothing (gaps allowed).
  - On in_valid=1 with cnt<D-1: acc<=acc+in_data, cnt<=cnt+1.
- Block completion (in_valid=1 and cnt==D-1):
  - sum = acc + in_data, at full width.
  - k = decim_log2 + frac_shift.
  - If k>0: r = (sum + 2^(k-1)) >>> k (round half toward +inf). Else r = sum.
  - Saturate r to signed out_width: max 2^(out_width-1)-1, min -2^(out_width-1). sat=1 if clipped.
  - acc<=0, cnt<=0 on the same edge.
  - With D=1, every valid sample completes a block.
- Output register:
  - Result appears on out_data/out_sat with out_valid=1 one cycle after the edge that captured the last sample of the block (latency 1 from the final in_valid).
  - Transfer occurs when out_valid && out_ready at an edge.
  - out_valid clears after transfer unless a new result loads on the same edge.
  - New result with out_valid=0: load.
  - New result with out_valid=1 and out_ready=1: old transfers, new loads, out_valid stays 1.
  - New result with out_valid=1 and out_ready=0: new result dropped, old held unchanged, overrun<=1. overrun stays 1 until rst.
  - out_data/out_sat are stable while out_valid=1 and out_ready=0.
  - out_ready is ignored when out_valid=0.
- Arithmetic: all two's complement, and >>> is an arithmetic shift.
- The intermediate rounding add must not overflow; widen by one bit.

Test Plan:
- Defaults; in_valid=1 continuously, samples 100,100,100,100; out_ready=1 -> one cycle after the 4th sample: out_valid=1 for 1 cycle, out_data=100, out_sat=0.
- Samples 10,10,10,11 -> out_data=10 (41+2>>>2). Samples -1,-1,-1,-1 -> -1. Samples -1,-1,0,0 -> 0 (half rounds up).
- Samples 40000 x4 -> out_data=32767, out_sat=1. Samples -40000 x4 -> out_data=-32768, out_sat=1.
- in_valid pattern 1,0,0,1,0,1,1 with samples 4,x,x,8,x,12,16 -> single result 10, one cycle after the 7th cycle. Gaps neither count nor accumulate.
- out_ready=0 across two complete blocks (results 5 then 9) -> out_data holds 5, overrun=1. Raise out_ready -> 5 transfers, out_valid drops, and 9 is never presented.
- Assert rst after 2 of 4 samples (values 1000,1000), then feed 4,4,4,4 -> out_data=4, showing the partial sum was cleared. All outputs are 0 during the reset cycle.
